mult_ctrl: RTL and testbench
============================

# mult_ctrl

Control FSM for the 16x9 shift-add sequential multiplier datapath. It accepts a start request and drives the load, clear, add and shift strobes that step the datapath through nine multiplier-bit iterations. It reports busy/done to the requester. It samples only the multiplier LSB fed back from the datapath, and replaces hand-stepping the datapath through control-ROM addresses.

## Interface
- N_ITER, 9: number of multiplier bits / iterations.
- CNT_W, 4: iteration counter width; must satisfy 2^CNT_W > N_ITER.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  request a multiply; sampled only in IDLE.
- abort  in  1  synchronous cancel; effective in any non-IDLE state.
- q0  in  1  current multiplier LSB from datapath Q register.
- clr_acc  out  1  clear accumulator.
- ld_a  out  1  load multiplicand register.
- ld_q  out  1  load multiplier register.
- add_en  out  1  accumulator += multiplicand.
- shift_en  out  1  shift {acc,Q} right one bit.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- last_cycles  out  5  present only with MULT_CYCLE_CNT_EN.

## Operation
- States: IDLE, LOAD, TEST, ADD, SHIFT, DONE.
- Outputs are a Moore decode of the state register only. No input-to-output combinational path exists.
- IDLE: all strobes 0. On start=1, go to LOAD. Iteration count is reloaded to N_ITER.
- LOAD: clr_acc=ld_a=ld_q=1. Next state is TEST.
- TEST: no strobes. If q0=1, go to ADD; otherwise go to SHIFT.
- ADD: add_en=1. Next state is SHIFT.
- SHIFT: shift_en=1. The count decrements. If count was 1, go to DONE; otherwise go to TEST.
- DONE: done=1, busy=1. Next state is IDLE unconditionally.
- abort=1 in LOAD/TEST/ADD/SHIFT/DONE: next state is IDLE. No done is issued, and no strobe is issued on the next cycle.
- Abort in SHIFT with count=1 takes priority over the transition to DONE.
- start while busy is ignored; it is not queued.
- start held high continuously gives back-to-back operations with exactly one IDLE cycle between DONE and LOAD.
- q0 is ignored outside TEST.

## Timing
- Reset values: state IDLE; count N_ITER; all outputs 0; last_cycles 0.
- RST asserted mid-operation forces IDLE immediately. All strobes drop asynchronously, and no done is issued.
- Latency: start is sampled at edge k, and LOAD is active in cycle k+1.
- Total busy cycles = 1 (LOAD) + 2·N_ITER (TEST+SHIFT) + p (ADD) + 1 (DONE), where p = number of 1 bits in the multiplier.
- For N_ITER=9, busy cycles range from 20 to 29.
- The product is valid in the datapath during the DONE cycle and stays valid until the next LOAD.

## Configuration
- MULT_CYCLE_CNT_EN defined:
  - A 5-bit counter clears in IDLE and increments in every busy cycle.
  - last_cycles loads the busy-cycle count (DONE included) on the edge leaving DONE, and holds until the next completion.
  - Aborted operations do not update last_cycles.
- MULT_CYCLE_CNT_EN undefined: the counter and the last_cycles port are absent. All other behaviour is identical.

## Structure
- Shared package mult_pkg:
  - state enum and its encoding (IDLE=0);
  - N_ITER default;
  - ITER_CNT_W;
  - the cycle-count width constant.
- One sub-module, mult_iter_cnt: loadable down-counter with a last-iteration flag (count==1), driven by load-in-IDLE and decrement-in-SHIFT.

## Test plan
- Multiplier 9'h000, start one pulse → busy 20 cycles, 0 add_en pulses, 9 shift_en pulses, done one cycle at busy cycle 20, last_cycles=20.
- Multiplier 9'h1FF → 9 add_en pulses, each immediately followed by shift_en; busy 29 cycles; last_cycles=29.
- Multiplier 9'h101 → add_en in iterations 1 and 9 only; busy 22 cycles.
- start re-pulsed during TEST/ADD, then start held high after DONE → first ignored; exactly one IDLE cycle, then LOAD.
- RST asserted during ADD of iteration 4 → all outputs 0 before the next edge, state IDLE, no done. A new start then gives the full-length operation.
- abort in final SHIFT (count=1) → IDLE next cycle, no done, last_cycles unchanged.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the 16x9 shift-add multiplier controller.
package mult_pkg;

  localparam int unsigned N_ITER_DEF = 9;
  localparam int unsigned ITER_CNT_W = 4;
  localparam int unsigned CYC_CNT_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TEST  = 3'd2,
    ST_ADD   = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic clr_acc;
    logic ld_a;
    logic ld_q;
    logic add_en;
    logic shift_en;
    logic busy;
    logic done;
  } ctrl_t;

  // Moore decode of the strobes that belong to a state
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c      = '0;
    c.busy = (s != ST_IDLE);
    case (s)
      ST_LOAD: begin
        c.clr_acc = 1'b1;
        c.ld_a    = 1'b1;
        c.ld_q    = 1'b1;
      end
      ST_ADD:   c.add_en   = 1'b1;
      ST_SHIFT: c.shift_en = 1'b1;
      ST_DONE:  c.done     = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mult_iter_cnt.sv
// Loadable iteration down-counter; flags the last multiplier-bit iteration.
module mult_iter_cnt
  import mult_pkg::*;
#(
  parameter int unsigned N_ITER = N_ITER_DEF,
  parameter int unsigned CNT_W  = ITER_CNT_W
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic dec,
  output logic last_c
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CNT_W'(N_ITER);
    end else if (dec) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= CNT_W'(N_ITER);
    end else begin
      count_q <= count_d;
    end
  end

  assign last_c = (count_q == CNT_W'(1));

endmodule

// File: rtl/mult_ctrl.sv
// Control FSM stepping the shift-add multiplier datapath through N_ITER iterations.
// Optional busy-cycle statistics output enabled by MULT_CYCLE_CNT_EN.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned N_ITER = N_ITER_DEF,
  parameter int unsigned CNT_W  = ITER_CNT_W
) (
  input  logic CLK,
  input  logic RST,
  input  logic start,
  input  logic abort,
  input  logic q0,
  output logic clr_acc,
  output logic ld_a,
  output logic ld_q,
  output logic add_en,
  output logic shift_en,
  output logic busy,
  output logic done
`ifdef MULT_CYCLE_CNT_EN
  ,
  output logic [CYC_CNT_W-1:0] last_cycles
`endif
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_d;
  logic   last_iter_c;
  logic   iter_load_c;
  logic   iter_dec_c;

  assign iter_load_c = (state_q == ST_IDLE);
  assign iter_dec_c  = (state_q == ST_SHIFT);

  mult_iter_cnt #(
    .N_ITER (N_ITER),
    .CNT_W  (CNT_W)
  ) u_iter_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .load   (iter_load_c),
    .dec    (iter_dec_c),
    .last_c (last_iter_c)
  );

  // State register; strobes are registered from the next-state decode
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_TEST;
      ST_TEST:  state_d = q0 ? ST_ADD : ST_SHIFT;
      ST_ADD:   state_d = ST_SHIFT;
      ST_SHIFT: state_d = last_iter_c ? ST_DONE : ST_TEST;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Cancel wins over every other transition, including SHIFT->DONE
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    ctrl_d = decode(state_d);
  end

  assign clr_acc  = ctrl_q.clr_acc;
  assign ld_a     = ctrl_q.ld_a;
  assign ld_q     = ctrl_q.ld_q;
  assign add_en   = ctrl_q.add_en;
  assign shift_en = ctrl_q.shift_en;
  assign busy     = ctrl_q.busy;
  assign done     = ctrl_q.done;

`ifdef MULT_CYCLE_CNT_EN
  logic [CYC_CNT_W-1:0] cyc_q;
  logic [CYC_CNT_W-1:0] cyc_d;
  logic [CYC_CNT_W-1:0] last_q;
  logic [CYC_CNT_W-1:0] last_d;

  // cyc_q counts busy cycles before the current one, so DONE adds one more
  always_comb begin
    cyc_d  = '0;
    last_d = last_q;
    if (state_q != ST_IDLE) begin
      cyc_d = cyc_q + CYC_CNT_W'(1);
    end
    if ((state_q == ST_DONE) && !abort) begin
      last_d = cyc_q + CYC_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cyc_q  <= '0;
      last_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      last_q <= last_d;
    end
  end

  assign last_cycles = last_q;
`endif

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl: per-cycle strobe sequence model plus a datapath stub.
module tb_mult_ctrl;

  localparam logic [6:0] V_IDLE  = 7'b0000000;
  localparam logic [6:0] V_LOAD  = 7'b1110010;
  localparam logic [6:0] V_TEST  = 7'b0000010;
  localparam logic [6:0] V_ADD   = 7'b0001010;
  localparam logic [6:0] V_SHIFT = 7'b0000110;
  localparam logic [6:0] V_DONE  = 7'b0000011;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic q0;
  logic clr_acc, ld_a, ld_q, add_en, shift_en, busy, done;
`ifdef MULT_CYCLE_CNT_EN
  logic [4:0] last_cycles;
`endif

  logic [8:0]  mult  = '0;
  logic [15:0] a_val = '0;
  logic [16:0] acc;
  logic [8:0]  qr;
  logic [15:0] a_reg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] exp_q[$];
  int seq_len = 0;
  logic [4:0] exp_last = '0;

  mult_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .abort       (abort),
    .q0          (q0),
    .clr_acc     (clr_acc),
    .ld_a        (ld_a),
    .ld_q        (ld_q),
    .add_en      (add_en),
    .shift_en    (shift_en),
    .busy        (busy),
    .done        (done)
`ifdef MULT_CYCLE_CNT_EN
    ,
    .last_cycles (last_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  // Minimal datapath obeying the strobes, so q0 and the product are real
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc   <= '0;
      qr    <= '0;
      a_reg <= '0;
    end else begin
      if (clr_acc) acc <= '0;
      if (ld_a) a_reg <= a_val;
      if (ld_q) qr <= mult;
      if (add_en) acc <= acc + {1'b0, a_reg};
      if (shift_en) {acc, qr} <= {acc, qr} >> 1;
    end
  end
  assign q0 = qr[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle strobe vectors for one full operation on multiplier m
  function automatic void build(input logic [8:0] m);
    exp_q.push_back(V_LOAD);
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(V_TEST);
      if (m[i]) exp_q.push_back(V_ADD);
      exp_q.push_back(V_SHIFT);
    end
    exp_q.push_back(V_DONE);
    seq_len = exp_q.size();
  endfunction

  function automatic int shifts_left();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i] == V_SHIFT) n++;
    return n;
  endfunction

  // Compare current cycle against the model, then advance it with the sampled inputs
  always @(negedge CLK) begin
    logic [6:0] expv;
    logic [6:0] dutv;
    dutv = {clr_acc, ld_a, ld_q, add_en, shift_en, busy, done};
    if (RST) begin
      exp_q.delete();
      exp_last = '0;
      expv = V_IDLE;
    end else begin
      expv = (exp_q.size() != 0) ? exp_q[0] : V_IDLE;
    end
    check("strobes", 32'(dutv), 32'(expv));
    if (!RST && expv == V_DONE)
      check("product", 32'({acc, qr}), 32'(26'(a_val) * 26'(mult)));
`ifdef MULT_CYCLE_CNT_EN
    check("last_cycles", 32'(last_cycles), 32'(exp_last));
`endif
    if (!RST) begin
      if (exp_q.size() != 0) begin
        if (abort) begin
          exp_q.delete();
        end else begin
          if (exp_q[0] == V_DONE) exp_last = 5'(seq_len);
          void'(exp_q.pop_front());
        end
      end else if (start) begin
        build(mult);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    check("wait_idle_timeout", 32'(exp_q.size() != 0), 32'd0);
  endtask

  task automatic wait_head(input logic [6:0] v, input int nshift);
    bit hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() != 0 && exp_q[0] == v && shifts_left() == nshift) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    check("wait_head_timeout", 32'(hit), 32'd1);
  endtask

  // One start pulse, then observe the DUT until it returns to idle
  task automatic run_op(input logic [8:0] m, input logic [15:0] a,
                        output int busy_n, output int add_n, output int shift_n,
                        output int done_at, output logic [8:0] add_mask, output int bad_pair);
    bit prev_add = 1'b0;
    busy_n = 0; add_n = 0; shift_n = 0; done_at = 0; add_mask = '0; bad_pair = 0;
    wait_idle();
    mult = m;
    a_val = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_latency", 32'(ld_q), 32'd1);
    for (int i = 0; i < 60 && busy; i++) begin
      busy_n++;
      if (add_en) begin
        add_n++;
        if (shift_n < 9) add_mask[shift_n] = 1'b1;
      end
      if (prev_add && !shift_en) bad_pair++;
      if (shift_en) shift_n++;
      if (done) done_at = busy_n;
      prev_add = add_en;
      tick();
    end
    check("op_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int bn, an, sn, da, bp, gap;
    logic [8:0] msk;

    #2;
    check("reset_strobes", 32'({clr_acc, ld_a, ld_q, add_en, shift_en, busy, done}), 32'd0);
`ifdef MULT_CYCLE_CNT_EN
    check("reset_last_cycles", 32'(last_cycles), 32'd0);
`endif
    tick();
    RST = 1'b0;
    tick();

    run_op(9'h000, 16'hBEEF, bn, an, sn, da, msk, bp);
    check("h000_busy", 32'(bn), 32'd20);
    check("h000_adds", 32'(an), 32'd0);
    check("h000_shifts", 32'(sn), 32'd9);
    check("h000_done_at", 32'(da), 32'd20);
`ifdef MULT_CYCLE_CNT_EN
    check("h000_last", 32'(last_cycles), 32'd20);
`endif

    run_op(9'h1FF, 16'hFFFF, bn, an, sn, da, msk, bp);
    check("h1ff_busy", 32'(bn), 32'd29);
    check("h1ff_adds", 32'(an), 32'd9);
    check("h1ff_add_then_shift", 32'(bp), 32'd0);
    check("h1ff_done_at", 32'(da), 32'd29);
`ifdef MULT_CYCLE_CNT_EN
    check("h1ff_last", 32'(last_cycles), 32'd29);
`endif

    run_op(9'h101, 16'h1234, bn, an, sn, da, msk, bp);
    check("h101_busy", 32'(bn), 32'd22);
    check("h101_add_iters", 32'(msk), 32'h101);

    // Start re-pulsed mid-operation, then held through DONE
    wait_idle();
    mult = 9'h0A5;
    a_val = 16'h0F0F;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_head(V_TEST, 9);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_head(V_ADD, 9);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_head(V_DONE, 0);
    start = 1'b1;
    gap = 0;
    tick();
    for (int i = 0; i < 10 && !ld_q; i++) begin
      if (!busy) gap++;
      tick();
    end
    start = 1'b0;
    check("b2b_idle_gap", 32'(gap), 32'd1);
    check("b2b_load", 32'(ld_q), 32'd1);

    // Reset during ADD of iteration 4
    wait_idle();
    mult = 9'h00F;
    a_val = 16'h8001;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_head(V_ADD, 6);
    #1 RST = 1'b1;
    #1;
    check("rst_async_strobes", 32'({clr_acc, ld_a, ld_q, add_en, shift_en, busy, done}), 32'd0);
    tick();
    RST = 1'b0;
    tick();
    run_op(9'h00F, 16'h8001, bn, an, sn, da, msk, bp);
    check("after_rst_busy", 32'(bn), 32'd24);
    check("after_rst_done_at", 32'(da), 32'd24);

    // Abort in the final SHIFT
    wait_idle();
    mult = 9'h1FF;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_head(V_SHIFT, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
`ifdef MULT_CYCLE_CNT_EN
    check("abort_last_kept", 32'(last_cycles), 32'd24);
`endif
    tick();
    check("abort_still_idle", 32'(busy), 32'd0);

    // Random traffic: start pulses, occasional aborts, new operands while idle
    for (int c = 0; c < 3000; c++) begin
      if (exp_q.size() == 0) begin
        mult = 9'($urandom);
        a_val = 16'($urandom);
      end
      start = ($urandom % 3) == 0;
      abort = ($urandom % 50) == 0;
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    wait_idle();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
